pipe_mem_stage: RTL

- MEM pipeline stage of the 5-stage MIPS CPU; upstream producer of the MEM→WB valid/allowin handshake consumed by the writeback stage.
- Latches EX results and issues the data-RAM access, 1-cycle synchronous read.
- Aligns and extends load data, detects address-error exceptions, and drives WB payload plus MEM-stage bypass.
- Honours the WB flush (exception/eret) by squashing the in-flight instruction and any pending memory side effect.

---
 rtl/pipe_mem_stage.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MEM stage of the 5-stage MIPS pipeline.
//   Latches EX results, issues the data-RAM access (1-cycle synchronous
//   read), aligns/extends load data, flags address errors and hands the
//   instruction to WB over a valid/allowin handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_mem_validto/mem_allowin  EX->MEM handshake
//   mem_wb_validto/wb_allowin   MEM->WB handshake
//   flush                    WB exception/eret squash of the MEM instruction
//   *_in                     EX payload
//   dm_*                     data-RAM port (word address, byte strobes)
//   wb_result_out, *_out     WB payload; bypass_mem/mem_rdc_valid forward path
module pipe_mem_stage #(
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_ADES = 5'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_validto,
  output logic        mem_allowin,
  input  logic        wb_allowin,
  output logic        mem_wb_validto,
  input  logic        flush,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        mem_en_in,
  input  logic [2:0]  mem_op_in,
  input  logic [4:0]  rdc_in,
  input  logic        rf_we_in,
  input  logic        bypass_rdc_valid_in,
  input  logic        cp0_rd_mux_sel_in,
  input  logic        cp0_we_in,
  input  logic        eret_flush_in,
  input  logic        branch_delay_in,
  input  logic        ex_in,
  input  logic [4:0]  ex_code_in,
  input  logic [4:0]  cp0_rdc_in,
  input  logic [31:0] cp0_data_in,
  input  logic [31:0] pc_in,
  output logic        dm_en,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic [31:0] wb_result_out,
  output logic [4:0]  rdc_mem,
  output logic        rf_we_out,
  output logic        bypass_rdc_valid_out,
  output logic        cp0_rd_mux_sel_out,
  output logic        cp0_we_out,
  output logic [4:0]  cp0_rdc_out,
  output logic [31:0] cp0_data_out,
  output logic [31:0] pc_out,
  output logic        branch_delay_out,
  output logic        eret_flush_out,
  output logic        ex_out,
  output logic [4:0]  ex_code_out,
  output logic [31:0] badvaddr_out,
  output logic [31:0] bypass_mem,
  output logic        mem_rdc_valid
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        mem_en;
    logic [2:0]  op;
    logic [4:0]  rdc;
    logic        rf_we;
    logic        byp;
    logic        cp0_sel;
    logic        cp0_we;
    logic        eret;
    logic        bd;
    logic        ex;
    logic [4:0]  ex_code;
    logic [4:0]  cp0_rdc;
    logic [31:0] cp0_data;
    logic [31:0] pc;
  } pay_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} st_t;

  pay_t        p;
  st_t         state, state_nx;
  logic        mem_valid, ready_go, hold_ld;
  logic        is_store, ade, access_ok;
  logic [31:0] hold_data, ld_data, rd_sh;
  logic [15:0] rd_half;

  // ---- handshake / payload ----
  assign mem_allowin    = !mem_valid | (ready_go & wb_allowin);
  assign mem_wb_validto = mem_valid & ready_go & !flush;

  always_ff @(posedge clk) begin
    if (rst || flush)     mem_valid <= 1'b0;
    else if (mem_allowin) mem_valid <= ex_mem_validto;
  end

  always_ff @(posedge clk) begin
    if (rst) p <= '0;
    else if (ex_mem_validto && mem_allowin)
      p <= '{alu: alu_result_in, sdata: store_data_in, mem_en: mem_en_in,
             op: mem_op_in, rdc: rdc_in, rf_we: rf_we_in, byp: bypass_rdc_valid_in,
             cp0_sel: cp0_rd_mux_sel_in, cp0_we: cp0_we_in, eret: eret_flush_in,
             bd: branch_delay_in, ex: ex_in, ex_code: ex_code_in,
             cp0_rdc: cp0_rdc_in, cp0_data: cp0_data_in, pc: pc_in};
  end

  // ---- address error ----
  assign is_store  = p.op[2] & (p.op[1] | p.op[0]);
  assign ade       = p.mem_en & !p.ex &
                     ((((p.op == OP_LW) | (p.op == OP_SW)) & (p.alu[1:0] != 2'b00)) |
                      (((p.op == OP_LH) | (p.op == OP_LHU) | (p.op == OP_SH)) & p.alu[0]));
  assign ex_out       = p.ex | ade;
  assign ex_code_out  = ade ? (is_store ? EXC_ADES : EXC_ADEL) : p.ex_code;
  assign badvaddr_out = ade ? p.alu : 32'h0;

  // A memory side effect only for a live, exception-free instruction that
  // is not being squashed this cycle.
  assign access_ok = mem_valid & p.mem_en & !ex_out & !flush;

  // ---- load alignment ----
  assign rd_sh   = dm_rdata >> {p.alu[1:0], 3'b000};
  assign rd_half = p.alu[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    case (p.op)
      OP_LB:   ld_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
      OP_LBU:  ld_data = {24'h0, rd_sh[7:0]};
      OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ld_data = {16'h0, rd_half};
      default: ld_data = dm_rdata;
    endcase
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst || flush) state <= S_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (access_ok && !is_store) state_nx = S_WAIT;
      S_WAIT:  state_nx = wb_allowin ? S_IDLE : S_HOLD;
      S_HOLD:  if (wb_allowin) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    dm_en    = 1'b0;
    dm_we    = 4'h0;
    ready_go = 1'b1;
    hold_ld  = 1'b0;
    case (state)
      S_IDLE: if (access_ok) begin
        dm_en = 1'b1;
        if (is_store) begin
          case (p.op)
            OP_SH:   dm_we = 4'b0011 << p.alu[1:0];
            OP_SB:   dm_we = 4'b0001 << p.alu[1:0];
            default: dm_we = 4'hF;
          endcase
        end else begin
          ready_go = 1'b0;  // read data arrives next cycle
        end
      end
      // dm_rdata is only valid for one cycle; keep it if WB stalls.
      S_WAIT:  hold_ld = !wb_allowin;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          hold_data <= 32'h0;
    else if (hold_ld) hold_data <= ld_data;
  end

  // ---- datapath outputs ----
  assign dm_addr = {p.alu[31:2], 2'b00};

  always_comb begin
    case (p.op)
      OP_SB:   dm_wdata = {4{p.sdata[7:0]}};
      OP_SH:   dm_wdata = {2{p.sdata[15:0]}};
      default: dm_wdata = p.sdata;
    endcase
  end

  always_comb begin
    case (state)
      S_WAIT:  wb_result_out = ld_data;
      S_HOLD:  wb_result_out = hold_data;
      default: wb_result_out = p.alu;
    endcase
  end

  assign bypass_mem           = wb_result_out;
  assign mem_rdc_valid        = p.byp & mem_valid & ready_go;
  assign rdc_mem              = p.rdc;
  assign rf_we_out            = p.rf_we;
  assign bypass_rdc_valid_out = p.byp;
  assign cp0_rd_mux_sel_out   = p.cp0_sel;
  assign cp0_we_out           = p.cp0_we;
  assign cp0_rdc_out          = p.cp0_rdc;
  assign cp0_data_out         = p.cp0_data;
  assign pc_out               = p.pc;
  assign branch_delay_out     = p.bd;
  assign eret_flush_out       = p.eret;
endmodule
